// File: rtl/vec_mem_sequencer.sv
// Vector memory sequencer: splits one LANES-wide vector load/store into LANES
// consecutive single-word accesses on a synchronous word memory.
module vec_mem_sequencer #(
    parameter int unsigned LANES = 16,
    parameter int unsigned AW    = 21,
    parameter int unsigned DW    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req,
    input  logic                      we,
    input  logic [AW-1:0]             addr,
    input  logic [LANES-1:0][DW-1:0]  wdata,
    output logic [LANES-1:0][DW-1:0]  rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_addr,
    output logic [DW-1:0]             mem_wdata,
    input  logic [DW-1:0]             mem_rdata
);

    localparam int unsigned CntW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CntW-1:0] LastLane = CntW'(LANES - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } stateT;

    stateT                     stateQ, stateD;
    logic [CntW-1:0]           cntQ, cntD;
    logic [AW-1:0]             baseQ;
    logic                      weQ;
    logic [LANES-1:0][DW-1:0]  wdataQ;
    logic [LANES-1:0][DW-1:0]  rdataQ;
    logic                      accept;
    logic                      capture;
    logic [CntW-1:0]           capLane;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StIdle;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    // Memory-side outputs are decoded from state so reset silences them at once.
    always_comb begin
        stateD    = stateQ;
        cntD      = cntQ;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (stateQ)
            StIdle: begin
                if (req) begin
                    accept = 1'b1;
                    cntD   = '0;
                    stateD = StIssue;
                end
            end
            StIssue: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = weQ;
                mem_addr  = baseQ + AW'(cntQ);
                mem_wdata = wdataQ[cntQ];
                cntD      = cntQ + CntOne;
                if (cntQ == LastLane) begin
                    stateD = weQ ? StDone : StDrain;
                end
            end
            StDrain: begin
                busy   = 1'b1;
                stateD = StDone;
            end
            StDone: begin
                done   = 1'b1;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baseQ  <= '0;
            weQ    <= 1'b0;
            wdataQ <= '0;
        end else if (accept) begin
            baseQ  <= addr;
            weQ    <= we;
            wdataQ <= wdata;
        end
    end

    // Read data trails the issue by one cycle: lane cnt-1 returns while lane cnt
    // is being issued, and the last lane returns during DRAIN.
    always_comb begin
        capture = 1'b0;
        capLane = cntQ - CntOne;
        if (!weQ) begin
            if (stateQ == StIssue && cntQ != '0) begin
                capture = 1'b1;
            end else if (stateQ == StDrain) begin
                capture = 1'b1;
                capLane = LastLane;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdataQ <= '0;
        end else if (capture) begin
            rdataQ[capLane] <= mem_rdata;
        end
    end

    assign rdata = rdataQ;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed, table-driven bench for vec_mem_sequencer with a behavioural
// synchronous word memory (unwritten word n reads as n*3).
module tb_vec_mem_sequencer;

    localparam int LANES = 16;
    localparam int AW    = 21;
    localparam int DW    = 32;

    logic                      clk;
    logic                      rst;
    logic                      req;
    logic                      we;
    logic [AW-1:0]             addr;
    logic [LANES-1:0][DW-1:0]  wdata;
    logic [LANES-1:0][DW-1:0]  rdata;
    logic                      busy;
    logic                      done;
    logic                      mem_en;
    logic                      mem_we;
    logic [AW-1:0]             mem_addr;
    logic [DW-1:0]             mem_wdata;
    logic [DW-1:0]             mem_rdata;

    vec_mem_sequencer #(
        .LANES (LANES),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] memArr [logic [AW-1:0]];

    function automatic logic [DW-1:0] rdWord(input logic [AW-1:0] a);
        if (memArr.exists(a) != 0) return memArr[a];
        return 32'(a) * 32'd3;
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) memArr[mem_addr] = mem_wdata;
            else        mem_rdata <= rdWord(mem_addr);
        end
    end

    typedef struct {
        logic          isStore;
        logic [AW-1:0] base;
        logic [31:0]   wbase;
        int            preLanes;   // leading lanes expected to hold the n*3 preload
        logic [31:0]   expBase;    // remaining lanes expect expBase + (lane - preLanes)
        int            expLat;
        int            expBusy;
    } vecT;

    vecT           vecs [6];
    logic [31:0]   expRd [LANES];
    int            nTests;
    int            nFail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] expLane(input vecT v, input int i);
        logic [AW-1:0] a;
        a = v.base + AW'(i);
        if (i < v.preLanes) return 32'(a) * 32'd3;
        return v.expBase + 32'(i - v.preLanes);
    endfunction

    task automatic setInputs(input vecT v);
        req  = 1'b1;
        we   = v.isStore;
        addr = v.base;
        for (int i = 0; i < LANES; i++) wdata[i] = v.wbase + 32'(i);
    endtask

    // Caller drives inputs before the accepting edge; returns at the negedge of done.
    task automatic runAccess(input vecT v, input bit holdReq, output int lat,
                             output int busyN, output int lanes, output int errs);
        logic [AW-1:0] expA;
        lat = -1; busyN = 0; lanes = 0; errs = 0;
        @(posedge clk);
        #1;
        addr = ~v.base;
        we   = ~v.isStore;
        for (int i = 0; i < LANES; i++) wdata[i] = 32'hDEAD_0000 + 32'(i);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) busyN++;
            if (mem_en) begin
                expA = v.base + AW'(lanes);
                if (mem_addr !== expA || mem_we !== v.isStore ||
                    (v.isStore && mem_wdata !== v.wbase + 32'(lanes))) errs++;
                lanes++;
            end
            if (done) begin
                lat = c;
                if (!holdReq) req = 1'b0;
                break;
            end
        end
        if (lat < 0) req = 1'b0;
    endtask

    task automatic checkAccess(input string tag, input vecT v, input int lat,
                               input int busyN, input int lanes, input int errs);
        check({tag, "_latency"}, 64'(lat), 64'(v.expLat));
        check({tag, "_busy_cycles"}, 64'(busyN), 64'(v.expBusy));
        check({tag, "_lanes_issued"}, 64'(lanes), 64'(LANES));
        check({tag, "_addr_data_errs"}, 64'(errs), 64'd0);
        if (!v.isStore) begin
            for (int i = 0; i < LANES; i++) expRd[i] = expLane(v, i);
        end
        for (int i = 0; i < LANES; i++) begin
            check($sformatf("%s_rdata%0d", tag, i), 64'(rdata[i]), 64'(expRd[i]));
        end
    endtask

    initial begin
        int   lat, busyN, lanes, errs;
        bit   found;
        vecT  b1, b2, rs, ld;

        vecs[0] = '{1'b1, 21'h00010,  32'hA000_0000, 0,  32'h0,         17, 16};
        vecs[1] = '{1'b0, 21'h00020,  32'h0,         16, 32'h0,         18, 17};
        vecs[2] = '{1'b0, 21'h1FFFF8, 32'h0,         16, 32'h0,         18, 17};
        vecs[3] = '{1'b0, 21'h00010,  32'h0,         0,  32'hA000_0000, 18, 17};
        vecs[4] = '{1'b1, 21'h1FFFFC, 32'h5000_0000, 0,  32'h0,         17, 16};
        vecs[5] = '{1'b0, 21'h1FFFFA, 32'h0,         2,  32'h5000_0000, 18, 17};

        nTests = 0;
        nFail  = 0;
        for (int i = 0; i < LANES; i++) expRd[i] = '0;
        rst = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; mem_rdata = '0;

        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_mem_en", 64'(mem_en), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata_zero", 64'(rdata === '0), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            setInputs(vecs[t]);
            runAccess(vecs[t], 1'b0, lat, busyN, lanes, errs);
            checkAccess($sformatf("vec%0d", t), vecs[t], lat, busyN, lanes, errs);
        end

        // Back-to-back stores with req held: one idle cycle between them.
        b1 = '{1'b1, 21'h00040, 32'h1111_0000, 0, 32'h0, 17, 16};
        b2 = '{1'b1, 21'h00060, 32'h2222_0000, 0, 32'h0, 17, 16};
        @(negedge clk);
        setInputs(b1);
        runAccess(b1, 1'b1, lat, busyN, lanes, errs);
        checkAccess("b2b_first", b1, lat, busyN, lanes, errs);
        setInputs(b2);
        @(negedge clk);
        check("b2b_gap_busy", 64'(busy), 64'd0);
        check("b2b_gap_mem_en", 64'(mem_en), 64'd0);
        check("b2b_gap_done", 64'(done), 64'd0);
        runAccess(b2, 1'b0, lat, busyN, lanes, errs);
        checkAccess("b2b_second", b2, lat, busyN, lanes, errs);

        // Reset during lane 5 of a store.
        rs = '{1'b1, 21'h00080, 32'hC000_0000, 0, 32'h0, 17, 16};
        @(negedge clk);
        setInputs(rs);
        @(posedge clk);
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_en && mem_addr == 21'h00085) begin
                found = 1'b1;
                break;
            end
        end
        check("rstmid_lane5_seen", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        check("rstmid_mem_we", 64'(mem_we), 64'd0);
        check("rstmid_mem_en", 64'(mem_en), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        check("rstmid_done", 64'(done), 64'd0);
        check("rstmid_rdata_zero", 64'(rdata === '0), 64'd1);
        for (int i = 0; i < LANES; i++) expRd[i] = '0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rstmid_word%0d", i), 64'(rdWord(21'h80 + AW'(i))),
                  64'(32'hC000_0000 + 32'(i)));
        end
        check("rstmid_word5_untouched", 64'(memArr.exists(21'h85)), 64'd0);

        // Request pending while reset releases is taken on the first edge.
        ld = '{1'b0, 21'h00085, 32'h0, 16, 32'h0, 18, 17};
        setInputs(ld);
        @(negedge clk);
        check("rstmid_no_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        runAccess(ld, 1'b0, lat, busyN, lanes, errs);
        checkAccess("post_rst_load", ld, lat, busyN, lanes, errs);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
